// File: rtl/axis_frame_gen_if.sv
// axis_frame_gen_if: AXI4-Stream video bundle for the frame generator.
// tuser marks start of frame, tlast marks end of line.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream video test-pattern generator (solid red, ramp, checker, colour bars).
// Define AXIS_FRAME_GEN_NOISE_EN to XOR pixels with a masked 32-bit Galois LFSR.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int H_RES      = 1920,
  parameter int V_RES      = 1080,
  parameter int LINE_GAP   = 0,
  parameter int FRAME_GAP  = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  input  logic [7:0]       noise_mask,
  axis_frame_gen_if.master m_axis,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LGAP   = 2'd2,
    FGAP   = 2'd3
  } state_t;

  localparam logic [10:0] X_LAST    = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_RES - 1);
  localparam logic [15:0] LGAP_LOAD = 16'((LINE_GAP > 0) ? (LINE_GAP - 1) : 0);
  localparam logic [15:0] FGAP_LOAD = 16'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);

  state_t      state;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic [1:0]  pat_q;
  logic [15:0] gap_cnt;
  logic        last_x;
  logic        last_y;
  logic        accept;
  logic [23:0] noise_cur;
  logic [23:0] noise_adv;

  function automatic logic [23:0] pattern_pix(input logic [1:0] sel, input logic [10:0] px,
                                              input logic py3);
    logic [2:0] bar;
    bar = 3'(({21'd0, px} * 32'd8) / 32'(H_RES));
    pattern_pix = 24'h000000;
    case (sel)
      2'd0:    pattern_pix = 24'hFF0000;
      2'd1:    pattern_pix = {3{px[7:0]}};
      2'd2:    pattern_pix = (px[3] ^ py3) ? 24'hFFFFFF : 24'h000000;
      default: begin
        case (bar)
          3'd0:    pattern_pix = 24'hFFFFFF;
          3'd1:    pattern_pix = 24'hFFFF00;
          3'd2:    pattern_pix = 24'h00FFFF;
          3'd3:    pattern_pix = 24'h00FF00;
          3'd4:    pattern_pix = 24'hFF00FF;
          3'd5:    pattern_pix = 24'hFF0000;
          3'd6:    pattern_pix = 24'h0000FF;
          default: pattern_pix = 24'h000000;
        endcase
      end
    endcase
  endfunction

  assign accept = m_axis.tvalid & m_axis.tready;
  assign last_x = (x == X_LAST);
  assign last_y = (y == Y_LAST);
  assign x_nxt  = last_x ? 11'd0 : (x + 11'd1);
  assign y_nxt  = last_x ? (last_y ? 11'd0 : (y + 11'd1)) : y;

`ifdef AXIS_FRAME_GEN_NOISE_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE1ACE1;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  logic [31:0] lfsr;
  logic [31:0] lfsr_nxt;

  // A beat presented on the acceptance edge must already see the advanced LFSR.
  assign lfsr_nxt  = lfsr[0] ? ({1'b0, lfsr[31:1]} ^ LFSR_TAPS) : {1'b0, lfsr[31:1]};
  assign noise_cur = lfsr[23:0] & {3{noise_mask}};
  assign noise_adv = lfsr_nxt[23:0] & {3{noise_mask}};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  logic unused_noise;
  assign unused_noise = ^noise_mask;
  assign noise_cur    = 24'h000000;
  assign noise_adv    = 24'h000000;
`endif

  // Output beat registers only change on acceptance, so a stall holds them stable.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      x             <= 11'd0;
      y             <= 11'd0;
      pat_q         <= 2'd0;
      gap_cnt       <= 16'd0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
      m_axis.tdata  <= '0;
      frame_done    <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= ACTIVE;
            pat_q         <= pattern_sel;
            x             <= 11'd0;
            y             <= 11'd0;
            m_axis.tvalid <= 1'b1;
            m_axis.tuser  <= 1'b1;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= DATA_WIDTH'(pattern_pix(pattern_sel, 11'd0, 1'b0) ^ noise_cur);
          end
        end
        ACTIVE: begin
          if (accept) begin
            x <= x_nxt;
            y <= y_nxt;
            if (last_x && last_y) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (FRAME_GAP > 0) begin
                state         <= FGAP;
                gap_cnt       <= FGAP_LOAD;
                m_axis.tvalid <= 1'b0;
                m_axis.tlast  <= 1'b0;
                m_axis.tuser  <= 1'b0;
              end else if (enable) begin
                pat_q         <= pattern_sel;
                m_axis.tvalid <= 1'b1;
                m_axis.tuser  <= 1'b1;
                m_axis.tlast  <= 1'b0;
                m_axis.tdata  <= DATA_WIDTH'(pattern_pix(pattern_sel, 11'd0, 1'b0) ^ noise_adv);
              end else begin
                state         <= IDLE;
                m_axis.tvalid <= 1'b0;
                m_axis.tlast  <= 1'b0;
                m_axis.tuser  <= 1'b0;
              end
            end else if (last_x && (LINE_GAP > 0)) begin
              state         <= LGAP;
              gap_cnt       <= LGAP_LOAD;
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              m_axis.tuser  <= 1'b0;
            end else begin
              m_axis.tvalid <= 1'b1;
              m_axis.tuser  <= 1'b0;
              m_axis.tlast  <= (x_nxt == X_LAST);
              m_axis.tdata  <= DATA_WIDTH'(pattern_pix(pat_q, x_nxt, y_nxt[3]) ^ noise_adv);
            end
          end
        end
        LGAP: begin
          if (gap_cnt == 16'd0) begin
            state         <= ACTIVE;
            m_axis.tvalid <= 1'b1;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= DATA_WIDTH'(pattern_pix(pat_q, x, y[3]) ^ noise_cur);
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        FGAP: begin
          if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
          end else if (enable) begin
            state         <= ACTIVE;
            pat_q         <= pattern_sel;
            m_axis.tvalid <= 1'b1;
            m_axis.tuser  <= 1'b1;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= DATA_WIDTH'(pattern_pix(pattern_sel, 11'd0, 1'b0) ^ noise_cur);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: directed stimulus plus a frame-level reference model checked every cycle.
// Built with or without AXIS_FRAME_GEN_NOISE_EN; the model follows the same macro.
module tb_axis_frame_gen;

  localparam int H_RES     = 4;
  localparam int V_RES     = 3;
  localparam int LINE_GAP  = 1;
  localparam int FRAME_GAP = 2;
  localparam int BEATS     = H_RES * V_RES;
  localparam logic [31:0] SEED = 32'hACE1ACE1;

  logic        aclk        = 1'b0;
  logic        aresetn     = 1'b0;
  logic        enable      = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [7:0]  noise_mask  = 8'd0;
  logic        frame_done;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  axis_frame_gen_if #(.DATA_WIDTH(32)) axis ();

  axis_frame_gen #(
    .DATA_WIDTH(32),
    .H_RES(H_RES),
    .V_RES(V_RES),
    .LINE_GAP(LINE_GAP),
    .FRAME_GAP(FRAME_GAP)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .noise_mask(noise_mask),
    .m_axis(axis),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  // Sink readiness: 0 always ready, 1 repeating 1,0,0,1, 2 never ready.
  int rdy_mode = 0;
  int rdy_cyc  = 0;
  always @(posedge aclk) begin
    #2;
    rdy_cyc = rdy_cyc + 1;
    case (rdy_mode)
      1:       axis.tready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
      2:       axis.tready = 1'b0;
      default: axis.tready = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int sel, input int px, input int py);
    logic [23:0] bar_colour [8];
    bar_colour = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (sel)
      0:       return 24'hFF0000;
      1:       return {3{8'(px)}};
      2:       return (((px / 8) + (py / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return bar_colour[(px * 8) / H_RES];
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Reference model state: beat index inside the frame, gaps, frame counting.
  int          beat_k      = 0;
  int          idle        = 0;
  int          exp_count   = 0;
  int          frame_pat   = 0;
  logic        in_frame    = 1'b0;
  logic        acc_final_d = 1'b0;
  logic        en_low_seen = 1'b1;
  logic        stall_d     = 1'b0;
  logic        rst_d       = 1'b0;
  logic        en_d        = 1'b0;
  logic [1:0]  sel_d       = 2'd0;
  logic [7:0]  mask_d      = 8'd0;
  logic [31:0] lfsr_m      = SEED;
  logic [31:0] held_data   = 32'd0;
  logic        held_last   = 1'b0;
  logic        held_user   = 1'b0;
  logic [31:0] acc_data [$];
  logic        acc_last [$];
  logic        acc_user [$];

  always @(negedge aclk) begin
    int px;
    int py;
    logic [23:0] noise;
    if (!rst_d) begin
      checkOutput("rst_tvalid", 32'(axis.tvalid), 32'd0);
      checkOutput("rst_tlast", 32'(axis.tlast), 32'd0);
      checkOutput("rst_tuser", 32'(axis.tuser), 32'd0);
      checkOutput("rst_tdata", axis.tdata, 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
      beat_k = 0; idle = 0; exp_count = 0; in_frame = 1'b0; acc_final_d = 1'b0;
      en_low_seen = 1'b1; stall_d = 1'b0; lfsr_m = SEED;
    end else begin
      if (acc_final_d) exp_count = (exp_count + 1) % 65536;
      checkOutput("frame_done", 32'(frame_done), 32'(acc_final_d));
      checkOutput("frame_count", 32'(frame_count), 32'(exp_count));
      acc_final_d = 1'b0;
      if (stall_d) begin
        checkOutput("stall_tvalid", 32'(axis.tvalid), 32'd1);
        checkOutput("stall_tdata", axis.tdata, held_data);
        checkOutput("stall_tlast", 32'(axis.tlast), 32'(held_last));
        checkOutput("stall_tuser", 32'(axis.tuser), 32'(held_user));
      end
      if (axis.tvalid) begin
        px = beat_k % H_RES;
        py = beat_k / H_RES;
        if (beat_k == 0 && !in_frame) begin
          in_frame  = 1'b1;
          frame_pat = int'(sel_d);
          checkOutput("start_enable", 32'(en_d), 32'd1);
          if (exp_count > 0 && !en_low_seen) checkOutput("frame_gap", 32'(idle), 32'(FRAME_GAP));
        end else if (!stall_d && px == 0 && py > 0) begin
          checkOutput("line_gap", 32'(idle), 32'(LINE_GAP));
        end
`ifdef AXIS_FRAME_GEN_NOISE_EN
        noise = lfsr_m[23:0] & {3{mask_d}};
`else
        noise = 24'h000000;
`endif
        checkOutput("tdata", axis.tdata, {8'h00, ref_pixel(frame_pat, px, py) ^ noise});
        checkOutput("tlast", 32'(axis.tlast), 32'(px == H_RES - 1));
        checkOutput("tuser", 32'(axis.tuser), 32'(beat_k == 0));
        held_data = axis.tdata;
        held_last = axis.tlast;
        held_user = axis.tuser;
        stall_d   = !axis.tready;
        if (axis.tready) begin
          acc_data.push_back(axis.tdata);
          acc_last.push_back(axis.tlast);
          acc_user.push_back(axis.tuser);
          lfsr_m = lfsr_step(lfsr_m);
          idle   = 0;
          if (beat_k == BEATS - 1) begin
            beat_k      = 0;
            in_frame    = 1'b0;
            acc_final_d = 1'b1;
            en_low_seen = 1'b0;
          end else begin
            beat_k++;
          end
        end
      end else begin
        idle++;
        stall_d = 1'b0;
        if (!en_d && !in_frame) en_low_seen = 1'b1;
      end
    end
    rst_d  = aresetn;
    en_d   = enable;
    sel_d  = pattern_sel;
    mask_d = noise_mask;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic [7:0] mask);
    enable      = en;
    pattern_sel = sel;
    noise_mask  = mask;
  endtask

  task automatic doReset();
    aresetn = 1'b0;
    tick(2);
    acc_data.delete();
    acc_last.delete();
    acc_user.delete();
    aresetn = 1'b1;
  endtask

  task automatic waitBeats(input int n, input int bound);
    int c = 0;
    while (acc_data.size() < n && c < bound) begin
      tick(1);
      c++;
    end
    if (acc_data.size() < n) checkOutput("beat_timeout", 32'(acc_data.size()), 32'(n));
  endtask

  task automatic waitFrames(input int n, input int bound);
    int c = 0;
    while (int'(frame_count) < n && c < bound) begin
      tick(1);
      c++;
    end
    if (int'(frame_count) < n) checkOutput("frame_timeout", 32'(frame_count), 32'(n));
  endtask

  logic [31:0] ramp_line [4] = '{32'h00000000, 32'h00010101, 32'h00020202, 32'h00030303};
  logic [31:0] bars_line [4] = '{32'h00FFFFFF, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF};
  logic [11:0] last_map      = 12'b1000_1000_1000;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, checks so far %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 2'd0, 8'd0);
    rdy_mode = 0;
    tick(3);
    doReset();
    tick(3);
    checkOutput("no_beat_without_enable", 32'(axis.tvalid), 32'd0);

    $display("[TB] ramp frame, always ready");
    applyStimulus(1'b1, 2'd1, 8'd0);
    @(negedge aclk);
    checkOutput("latency_before", 32'(axis.tvalid), 32'd0);
    @(negedge aclk);
    checkOutput("latency_first_valid", 32'(axis.tvalid), 32'd1);
    checkOutput("latency_first_tuser", 32'(axis.tuser), 32'd1);
    waitFrames(1, 100);
    applyStimulus(1'b0, 2'd1, 8'd0);
    tick(10);
    checkOutput("ramp_beats", 32'(acc_data.size()), 32'd12);
    for (int i = 0; i < acc_data.size() && i < 12; i++) begin
      checkOutput("ramp_tdata", acc_data[i], ramp_line[i % 4]);
      checkOutput("ramp_tlast", 32'(acc_last[i]), 32'(last_map[i]));
      checkOutput("ramp_tuser", 32'(acc_user[i]), 32'(i == 0));
    end
    checkOutput("ramp_frame_count", 32'(frame_count), 32'd1);
    checkOutput("ramp_idle_after", 32'(axis.tvalid), 32'd0);

    $display("[TB] bars frame, ready toggling 1,0,0,1");
    doReset();
    rdy_mode = 1;
    applyStimulus(1'b1, 2'd3, 8'd0);
    waitFrames(1, 200);
    applyStimulus(1'b0, 2'd3, 8'd0);
    rdy_mode = 0;
    tick(10);
    checkOutput("bars_beats", 32'(acc_data.size()), 32'd12);
    for (int i = 0; i < acc_data.size() && i < 12; i++) begin
      checkOutput("bars_tdata", acc_data[i], bars_line[i % 4]);
    end

    $display("[TB] enable dropped after beat 5");
    doReset();
    applyStimulus(1'b1, 2'd0, 8'd0);
    waitBeats(5, 100);
    applyStimulus(1'b0, 2'd0, 8'd0);
    waitFrames(1, 100);
    tick(30);
    checkOutput("drop_beats", 32'(acc_data.size()), 32'd12);
    checkOutput("drop_frame_count", 32'(frame_count), 32'd1);
    checkOutput("drop_idle", 32'(axis.tvalid), 32'd0);
    if (acc_data.size() == 12) checkOutput("drop_last_data", acc_data[11], 32'h00FF0000);

    $display("[TB] pattern change mid-frame");
    doReset();
    applyStimulus(1'b1, 2'd0, 8'd0);
    waitBeats(6, 100);
    applyStimulus(1'b1, 2'd2, 8'd0);
    waitFrames(2, 200);
    applyStimulus(1'b0, 2'd2, 8'd0);
    tick(10);
    checkOutput("pat_beats", 32'(acc_data.size()), 32'd24);
    for (int i = 0; i < acc_data.size() && i < 24; i++) begin
      checkOutput("pat_tdata", acc_data[i], (i < 12) ? 32'h00FF0000 : 32'h00000000);
    end
    checkOutput("pat_frame_count", 32'(frame_count), 32'd2);

    $display("[TB] reset during stall");
    doReset();
    applyStimulus(1'b1, 2'd1, 8'd0);
    waitBeats(6, 100);
    rdy_mode = 2;
    tick(3);
    checkOutput("stall_before_reset", 32'(axis.tvalid), 32'd1);
    applyStimulus(1'b0, 2'd1, 8'd0);
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("reset_clears_tvalid", 32'(axis.tvalid), 32'd0);
    checkOutput("reset_clears_tdata", axis.tdata, 32'd0);
    tick(5);
    checkOutput("no_resume", 32'(axis.tvalid), 32'd0);
    acc_data.delete();
    acc_last.delete();
    acc_user.delete();
    rdy_mode = 0;
    applyStimulus(1'b1, 2'd1, 8'd0);
    waitFrames(1, 100);
    applyStimulus(1'b0, 2'd1, 8'd0);
    tick(10);
    checkOutput("restart_beats", 32'(acc_data.size()), 32'd12);
    if (acc_data.size() > 0) begin
      checkOutput("restart_tuser", 32'(acc_user[0]), 32'd1);
      checkOutput("restart_tdata", acc_data[0], 32'h00000000);
    end

    $display("[TB] noise mask 0xFF");
    doReset();
    applyStimulus(1'b1, 2'd1, 8'hFF);
    waitFrames(1, 100);
    applyStimulus(1'b0, 2'd1, 8'hFF);
    tick(10);
    checkOutput("noise_beats", 32'(acc_data.size()), 32'd12);
    if (acc_data.size() > 1) begin
`ifdef AXIS_FRAME_GEN_NOISE_EN
      checkOutput("noise_beat0", acc_data[0], 32'h00E1ACE1);
      checkOutput("noise_beat1", acc_data[1], 32'h0051D772);
`else
      checkOutput("noise_beat0", acc_data[0], 32'h00000000);
      checkOutput("noise_beat1", acc_data[1], 32'h00010101);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
